// File: rtl/eb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eb_arb_pkg
// Description : Shared definitions for the elastic-buffer round-robin arbiter.
//               Provides the source-index width helper and the buffer-slot
//               record type stored in the two-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package eb_arb_pkg;

    // Upper bounds for the fields of the shared slot record. An instance uses
    // only the low DW / SW bits; the rest stay zero and are trimmed away.
    localparam int unsigned c_dw_max = 1024;
    localparam int unsigned c_sw_max = 16;

    // Source-index width: max(1, clog2(n)).
    function automatic int unsigned sw_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One buffered beat.
    typedef struct packed {
        logic [c_dw_max-1:0] data;
        logic [c_sw_max-1:0] src;
        logic                last;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req found searching upward from ptr, modulo N.
// Ports       : req [N]  - request vector
//               ptr [SW] - highest-priority index this cycle
//               gnt [N]  - one-hot grant (all zero when nothing requested)
//               idx [SW] - index of the granted bit
//               any      - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    // Walk the offsets from farthest to nearest so the nearest requester to
    // ptr is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                         = '0;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                idx                         = SW'((int'(ptr) + k) % N);
                any                         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : eb_rr_arb
// Description : N-input round-robin arbiter feeding a two-slot output FIFO.
//               Input accept (ready_o) depends only on registered occupancy,
//               so there is no combinational path from ready_i to ready_o.
//               Optional packet lock: define EB_ARB_PKT_LOCK_EN to add the
//               last_i / last_o ports and keep a grant until the last beat.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               data_i  [N*DW]   - requester payloads (requester k at k*DW)
//               valid_i [N]      - requester valid
//               ready_o [N]      - per-requester accept (at most one high)
//               last_i  [N]      - end-of-packet flags (lock build only)
//               data_o  [DW]     - payload of the oldest buffered beat
//               valid_o          - FIFO not empty
//               ready_i          - downstream accept
//               src_o   [SW]     - requester index of the beat on data_o
//               last_o           - last flag of that beat (lock build only)
// Revision    : 1.0 - initial release
// ============================================================================
module eb_rr_arb
    import eb_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32   // must not exceed c_dw_max
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DW-1:0]       data_i,
    input  logic [N-1:0]          valid_i,
    output logic [N-1:0]          ready_o,
`ifdef EB_ARB_PKT_LOCK_EN
    input  logic [N-1:0]          last_i,
`endif
    output logic [DW-1:0]         data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [sw_of(N)-1:0]   src_o
`ifdef EB_ARB_PKT_LOCK_EN
    ,
    output logic                  last_o
`endif
);

    localparam int unsigned c_sw = sw_of(N);

    logic [1:0]      r_cnt;
    logic [c_sw-1:0] r_ptr;
    slot_t           r_head;     // oldest beat, drives the outputs
    slot_t           r_tail;     // second beat when r_cnt == 2
    logic            r_live;     // low for the first cycle after reset

`ifdef EB_ARB_PKT_LOCK_EN
    logic            r_lock;
    logic [c_sw-1:0] r_lock_src;
    logic [N-1:0]    w_lock_mask;
`endif

    logic [N-1:0]    w_req;
    logic [N-1:0]    w_gnt;
    logic [c_sw-1:0] w_idx;
    logic            w_any;
    logic            w_room;
    logic            w_push;
    logic            w_pop;
    logic [c_sw-1:0] w_ptr_inc;
    slot_t           w_new;
    logic            w_unused_bits;

    // ------------------------------------------------------------------
    // Request filtering and arbitration
    // ------------------------------------------------------------------
`ifdef EB_ARB_PKT_LOCK_EN
    always_comb begin
        w_lock_mask = '0;
        for (int k = 0; k < N; k++) begin
            w_lock_mask[k] = (r_lock_src == c_sw'(k));
        end
    end

    assign w_req = r_lock ? (valid_i & w_lock_mask) : valid_i;
`else
    assign w_req = valid_i;
`endif

    rr_pick #(
        .N  (N),
        .SW (c_sw)
    ) u_pick (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    // Room is purely registered state; downstream ready never reaches here.
    assign w_room  = r_live & (r_cnt != 2'd2);
    assign ready_o = w_room ? w_gnt : '0;
    assign w_push  = w_room & w_any;

    assign valid_o = (r_cnt != 2'd0);
    assign w_pop   = valid_o & ready_i;

    assign w_ptr_inc = (w_idx == c_sw'(N - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_new                = '0;
        w_new.data[DW-1:0]   = data_i[int'(w_idx) * DW +: DW];
        w_new.src[c_sw-1:0]  = w_idx;
`ifdef EB_ARB_PKT_LOCK_EN
        w_new.last           = last_i[w_idx];
`endif
    end

    // ------------------------------------------------------------------
    // Two-slot FIFO, pointer and lock state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_ptr  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_live <= 1'b0;
`ifdef EB_ARB_PKT_LOCK_EN
            r_lock     <= 1'b0;
            r_lock_src <= '0;
`endif
        end else begin
            r_live <= 1'b1;

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= w_new;
                    end else begin
                        r_tail <= w_new;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_tail <= '0;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new beat lands behind the
                    // survivor (or becomes the head if there is none).
                    if (r_cnt == 2'd1) begin
                        r_head <= w_new;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_new;
                    end
                end
                default: ;
            endcase

            if (w_push) begin
`ifdef EB_ARB_PKT_LOCK_EN
                // Pointer only moves when a packet ends; mid-packet beats
                // (re)arm the lock on the current winner.
                if (w_new.last) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_ptr_inc;
                end else begin
                    r_lock     <= 1'b1;
                    r_lock_src <= w_idx;
                end
`else
                r_ptr <= w_ptr_inc;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_o = r_head.data[DW-1:0];
    assign src_o  = r_head.src[c_sw-1:0];
`ifdef EB_ARB_PKT_LOCK_EN
    assign last_o = r_head.last;
`endif

    // Slot bits above DW / SW (and last when unlocked) are constant zero and
    // never read; fold them into one named sink.
    assign w_unused_bits = ^{r_head, r_tail};

endmodule
`default_nettype wire

// File: tb/tb_eb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_eb_rr_arb
// Description : Self-checking bench for eb_rr_arb. A 4-requester instance is
//               driven from a directed vector table plus hand sequences for
//               reset-with-full-buffer and packet lock; a 1-requester 8-bit
//               instance gets random traffic against an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eb_rr_arb;

    logic clk;
    logic rst;

    // 4-requester instance
    logic [127:0] d4_data;
    logic [3:0]   d4_valid;
    logic [3:0]   d4_ready;
    logic [3:0]   d4_last;
    logic [31:0]  d4_dout;
    logic         d4_vout;
    logic         d4_rdy_in;
    logic [1:0]   d4_src;
`ifdef EB_ARB_PKT_LOCK_EN
    logic         d4_last_o;
`endif

    // 1-requester instance
    logic [7:0]   d1_data;
    logic [0:0]   d1_valid;
    logic [0:0]   d1_ready;
    logic [7:0]   d1_dout;
    logic         d1_vout;
    logic         d1_rdy;
    logic [0:0]   d1_src;
`ifdef EB_ARB_PKT_LOCK_EN
    logic [0:0]   d1_last;
    logic         d1_last_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    eb_rr_arb #(.N(4), .DW(32)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .data_i  (d4_data),
        .valid_i (d4_valid),
        .ready_o (d4_ready),
`ifdef EB_ARB_PKT_LOCK_EN
        .last_i  (d4_last),
`endif
        .data_o  (d4_dout),
        .valid_o (d4_vout),
        .ready_i (d4_rdy_in),
        .src_o   (d4_src)
`ifdef EB_ARB_PKT_LOCK_EN
        ,
        .last_o  (d4_last_o)
`endif
    );

    eb_rr_arb #(.N(1), .DW(8)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .data_i  (d1_data),
        .valid_i (d1_valid),
        .ready_o (d1_ready),
`ifdef EB_ARB_PKT_LOCK_EN
        .last_i  (d1_last),
`endif
        .data_o  (d1_dout),
        .valid_o (d1_vout),
        .ready_i (d1_rdy),
        .src_o   (d1_src)
`ifdef EB_ARB_PKT_LOCK_EN
        ,
        .last_o  (d1_last_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic [3:0] e_rdy;
        logic       e_vo;
        logic [1:0] e_src;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus to the 4-requester DUT, check it, advance.
    task automatic cyc(input string tag, input logic [3:0] v, input logic r,
                       input logic [3:0] lst, input logic [3:0] e_rdy,
                       input logic e_vo, input logic [1:0] e_src,
                       input logic e_lo, input logic chk_lo);
        d4_valid  = v;
        d4_rdy_in = r;
        d4_last   = lst;
        #1;
        chk({tag, ".ready"}, 32'(d4_ready), 32'(e_rdy));
        chk({tag, ".valid"}, 32'(d4_vout), 32'(e_vo));
        if (e_vo) begin
            chk({tag, ".src"},  32'(d4_src), 32'(e_src));
            chk({tag, ".data"}, d4_dout, 32'hD0 + 32'(e_src));
        end
`ifdef EB_ARB_PKT_LOCK_EN
        if (chk_lo && e_vo) chk({tag, ".last"}, 32'(d4_last_o), 32'(e_lo));
`endif
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q [$];

    initial begin
        // Requester k always offers 0xD0 + k.
        d4_data   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        d4_valid  = 4'b0000;
        d4_rdy_in = 1'b0;
        d4_last   = 4'b1111;
        d1_data   = 8'h00;
        d1_valid  = 1'b0;
        d1_rdy    = 1'b0;
`ifdef EB_ARB_PKT_LOCK_EN
        d1_last   = 1'b1;
`endif
        rst = 1'b1;

        //                v        r     e_rdy    vo    src
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
        tbl[8]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0};
        tbl[9]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd0};
        tbl[10] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[12] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[16] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[17] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // First cycle after reset: everything quiet even with requests up.
        d4_valid  = 4'b1111;
        d4_rdy_in = 1'b1;
        d1_valid  = 1'b1;
        d1_data   = 8'h5A;
        #1;
        chk("rst.ready",  32'(d4_ready), 32'h0);
        chk("rst.valid",  32'(d4_vout),  32'h0);
        chk("rst.data",   d4_dout,       32'h0);
        chk("rst.src",    32'(d4_src),   32'h0);
        chk("rst1.ready", 32'(d1_ready), 32'h0);
        chk("rst1.valid", 32'(d1_vout),  32'h0);
        chk("rst1.data",  32'(d1_dout),  32'h0);
`ifdef EB_ARB_PKT_LOCK_EN
        chk("rst.last",   32'(d4_last_o), 32'h0);
`endif
        d1_valid = 1'b0;
        @(posedge clk);
        #1;
        // The N=1 instance stays idle until its own test; its rst-cycle
        // request was not accepted, so its FIFO is still empty.

        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("t%0d", i), tbl[i].v, tbl[i].r, 4'b1111,
                tbl[i].e_rdy, tbl[i].e_vo, tbl[i].e_src, 1'b0, 1'b0);
        end

        // Reset with a full buffer (and, in the lock build, a held lock).
        // ptr is 3 here.
        cyc("b1", 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
`ifdef EB_ARB_PKT_LOCK_EN
        cyc("b2", 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
`else
        cyc("b2", 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd3, 1'b0, 1'b0);
`endif
        rst = 1'b1;
        cyc("b3", 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
        rst = 1'b0;
        d4_valid  = 4'b1111;
        d4_rdy_in = 1'b1;
        d4_last   = 4'b1111;
        #1;
        chk("b4.data", d4_dout,     32'h0);
        chk("b4.src",  32'(d4_src), 32'h0);
        cyc("b4", 4'b1111, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc("b5", 4'b1111, 1'b1, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc("b6", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

`ifdef EB_ARB_PKT_LOCK_EN
        // Packet lock: requester 2 sends a 3-beat packet while 0 and 1 wait.
        cyc("p",  4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc("L1", 4'b0111, 1'b1, 4'b0011, 4'b0100, 1'b1, 2'd1, 1'b1, 1'b1);
        cyc("L2", 4'b0111, 1'b1, 4'b0011, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
        cyc("L3", 4'b0111, 1'b1, 4'b0111, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
        cyc("L4", 4'b0011, 1'b1, 4'b0011, 4'b0001, 1'b1, 2'd2, 1'b1, 1'b1);
        cyc("L5", 4'b0011, 1'b1, 4'b0011, 4'b0010, 1'b1, 2'd0, 1'b1, 1'b1);
        cyc("L6", 4'b0000, 1'b1, 4'b0011, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b1);
        cyc("L7", 4'b0000, 1'b1, 4'b0011, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
`endif

        // N=1: random traffic, output must match input order exactly.
        d4_valid = 4'b0000;
        for (int c = 0; c < 1004; c++) begin
            if (c < 1000) begin
                d1_valid = 1'($urandom_range(0, 1));
                d1_rdy   = 1'($urandom_range(0, 1));
                d1_data  = 8'($urandom);
            end else begin
                d1_valid = 1'b0;
                d1_rdy   = 1'b1;
            end
            #1;
            if (d1_vout && d1_rdy) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL n1.extra: got beat %0h expected none", d1_dout);
                end else begin
                    chk($sformatf("n1.data%0d", c), 32'(d1_dout), 32'(q.pop_front()));
                end
                chk("n1.src", 32'(d1_src), 32'h0);
            end
            if (d1_valid[0] && d1_ready[0]) q.push_back(d1_data);
            @(posedge clk);
            #1;
        end
        chk("n1.left",  32'(q.size()), 32'h0);
        chk("n1.valid", 32'(d1_vout),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
